// File: rtl/rs232_pkg.sv
// Shared RS-232 framing constants and parser state encoding.
// The TX serializer reuses the byte constants for response framing.
package rs232_pkg;

  localparam logic [7:0] STX = 8'h02;
  localparam logic [7:0] ETX = 8'h03;
  localparam logic [7:0] PAD = 8'h00;

  localparam int unsigned FRAME_LEN     = 8;
  localparam int unsigned DATA_BYTES    = 4;
  localparam int unsigned CMD_DATA_W    = 32;
  localparam int unsigned TIMEOUT_W     = 16;
  localparam int unsigned CMD_WRITE_BIT = 7;
  localparam int unsigned CMD_ADDR_MSB  = 6;
  localparam int unsigned CMD_ADDR_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA,
    ST_PAD,
    ST_ETX,
    ST_ISSUE
  } parser_state_e;

endpackage

// File: rtl/rs232_frame_parser_if.sv
// Byte-in / command-out handshake bundle of the frame parser.
// master = parser side, slave = UART receiver plus command consumer.
interface rs232_frame_parser_if
  import rs232_pkg::*;
#(
  parameter int unsigned ADDR_W = 7
);

  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_W-1:0]     cmd_addr;
  logic [CMD_DATA_W-1:0] cmd_wdata;

  modport master (
    input  rx_data, rx_valid, cmd_ready,
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata
  );

  modport slave (
    output rx_data, rx_valid, cmd_ready,
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata
  );

endinterface

// File: rtl/rs232_frame_parser.sv
// Assembles STX/CMD/D3..D0/PAD/ETX host frames into one read/write command.
// Bad PAD/ETX or an inter-byte timeout drops the frame and resyncs on STX.
module rs232_frame_parser
  import rs232_pkg::*;
#(
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_CYCLES = 16'd50000,
  parameter int unsigned          ADDR_W         = 7
) (
  input  logic                 clk,
  input  logic                 rst,
  rs232_frame_parser_if.master bus,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  parser_state_e         state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
  logic                  write_q, write_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [CMD_DATA_W-1:0] wdata_q, wdata_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  logic                  ovr_q, ovr_d;
  logic                  busy_q, busy_d;
  logic                  in_frame_c;
  logic                  timeout_c;

  // Timeout fires on the edge where the idle count would reach TIMEOUT_CYCLES
  assign in_frame_c = (state_q == ST_CMD) || (state_q == ST_DATA) ||
                      (state_q == ST_PAD) || (state_q == ST_ETX);
  assign timeout_c  = in_frame_c && (TIMEOUT_CYCLES != '0) &&
                      (cnt_q == TIMEOUT_CYCLES - TIMEOUT_W'(1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = '0;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = ovr_q;

    if (in_frame_c) begin
      cnt_d = bus.rx_valid ? '0 : cnt_q + TIMEOUT_W'(1);
    end

    if (timeout_c) begin
      state_d = ST_IDLE;
      ferr_d  = 1'b1;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.rx_valid && bus.rx_data == STX) begin
            state_d = ST_CMD;
          end
        end
        ST_CMD: begin
          if (bus.rx_valid) begin
            write_d = bus.rx_data[CMD_WRITE_BIT];
            addr_d  = ADDR_W'(bus.rx_data[CMD_ADDR_MSB:CMD_ADDR_LSB]);
            idx_d   = 2'd0;
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          if (bus.rx_valid) begin
            wdata_d = {wdata_q[CMD_DATA_W-9:0], bus.rx_data};
            idx_d   = idx_q + 2'd1;
            if (idx_q == 2'(DATA_BYTES - 1)) begin
              state_d = ST_PAD;
            end
          end
        end
        ST_PAD: begin
          if (bus.rx_valid) begin
            if (bus.rx_data == PAD) begin
              state_d = ST_ETX;
            end else begin
              ferr_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
        ST_ETX: begin
          if (bus.rx_valid) begin
            if (bus.rx_data == ETX) begin
              valid_d = 1'b1;
              state_d = ST_ISSUE;
            end else begin
              ferr_d  = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
        ST_ISSUE: begin
          // A byte arriving while a command is pending is lost
          if (bus.rx_valid) begin
            ovr_d = 1'b1;
          end
          if (valid_q && bus.cmd_ready) begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.cmd_valid = valid_q;
  assign bus.cmd_write = write_q;
  assign bus.cmd_addr  = addr_q;
  assign bus.cmd_wdata = wdata_q;
  assign frame_err     = ferr_q;
  assign overrun       = ovr_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_rs232_frame_parser.sv
// Directed-vector bench for rs232_frame_parser with hand-computed expectations.
module tb_rs232_frame_parser;
  import rs232_pkg::*;

  localparam int unsigned ADDR_W = 7;

  logic clk;
  logic rst;
  logic frame_err;
  logic overrun;
  logic busy;

  int n_checks = 0;
  int n_errors = 0;
  int acc_cnt  = 0;
  int ferr_cnt = 0;

  rs232_frame_parser_if #(.ADDR_W(ADDR_W)) bus ();

  rs232_frame_parser #(
    .TIMEOUT_CYCLES(16'd16),
    .ADDR_W        (ADDR_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count handshakes and error pulses as seen at the active edge
  always @(posedge clk) begin
    if (rst && bus.cmd_valid && bus.cmd_ready) acc_cnt <= acc_cnt + 1;
    if (rst && frame_err) ferr_cnt <= ferr_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; byte is sampled by the next posedge, returns at the following negedge
  task automatic send_byte(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [31:0] d,
                            input logic [7:0] pad, input logic [7:0] etx);
    logic [31:0] dd;
    dd = d;
    send_byte(8'h02);
    send_byte(cmd);
    send_byte(dd[31:24]);
    send_byte(dd[23:16]);
    send_byte(dd[15:8]);
    send_byte(dd[7:0]);
    send_byte(pad);
    send_byte(etx);
  endtask

  int acc0;
  int ferr0;
  int hi_cycles;
  int early_err;

  initial begin
    rst           = 1'b0;
    bus.rx_data   = 8'h00;
    bus.rx_valid  = 1'b0;
    bus.cmd_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_cmd_valid", 64'(bus.cmd_valid), 64'd0);
    check_eq("rst_busy",      64'(busy),          64'd0);
    check_eq("rst_outputs",   64'({bus.cmd_write, bus.cmd_addr, bus.cmd_wdata, frame_err, overrun}), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // Write frame, latency of exactly one cycle after ETX
    bus.cmd_ready = 1'b1;
    acc0 = acc_cnt;
    send_byte(8'h02); send_byte(8'hFF); send_byte(8'h04); send_byte(8'h08);
    send_byte(8'h16); send_byte(8'h32); send_byte(8'h00);
    check_eq("t1_busy_mid", 64'(busy), 64'd1);
    check_eq("t1_valid_before_etx", 64'(bus.cmd_valid), 64'd0);
    send_byte(8'h03);
    check_eq("t1_valid", 64'(bus.cmd_valid), 64'd1);
    check_eq("t1_write", 64'(bus.cmd_write), 64'd1);
    check_eq("t1_addr",  64'(bus.cmd_addr),  64'h7F);
    check_eq("t1_wdata", 64'(bus.cmd_wdata), 64'h04081632);
    @(negedge clk);
    check_eq("t1_valid_drop", 64'(bus.cmd_valid), 64'd0);
    check_eq("t1_accepts", 64'(acc_cnt - acc0), 64'd1);
    check_eq("t1_idle", 64'(busy), 64'd0);

    // Read frame with backpressure: 5 stalled cycles then accept
    bus.cmd_ready = 1'b0;
    acc0 = acc_cnt;
    hi_cycles = 0;
    send_frame(8'h7E, 32'h0, 8'h00, 8'h03);
    for (int i = 0; i < 5; i++) begin
      if (bus.cmd_valid) hi_cycles++;
      @(negedge clk);
    end
    bus.cmd_ready = 1'b1;
    if (bus.cmd_valid) hi_cycles++;
    check_eq("t2_write", 64'(bus.cmd_write), 64'd0);
    check_eq("t2_addr",  64'(bus.cmd_addr),  64'h7E);
    @(negedge clk);
    bus.cmd_ready = 1'b0;
    check_eq("t2_valid_drop", 64'(bus.cmd_valid), 64'd0);
    check_eq("t2_hi_cycles", 64'(hi_cycles), 64'd6);
    check_eq("t2_accepts", 64'(acc_cnt - acc0), 64'd1);
    check_eq("t2_addr_kept", 64'(bus.cmd_addr), 64'h7E);

    // Leading garbage is ignored silently
    bus.cmd_ready = 1'b1;
    ferr0 = ferr_cnt;
    acc0 = acc_cnt;
    send_byte(8'h55); send_byte(8'hAA);
    check_eq("t3_busy_garbage", 64'(busy), 64'd0);
    send_frame(8'hFE, 32'h0A0B0C0D, 8'h00, 8'h03);
    check_eq("t3_valid", 64'(bus.cmd_valid), 64'd1);
    check_eq("t3_write", 64'(bus.cmd_write), 64'd1);
    check_eq("t3_addr",  64'(bus.cmd_addr),  64'h7E);
    check_eq("t3_wdata", 64'(bus.cmd_wdata), 64'h0A0B0C0D);
    @(negedge clk);
    check_eq("t3_no_ferr", 64'(ferr_cnt - ferr0), 64'd0);
    check_eq("t3_accepts", 64'(acc_cnt - acc0), 64'd1);

    // Bad PAD then bad ETX, then a good frame
    ferr0 = ferr_cnt;
    acc0 = acc_cnt;
    send_frame(8'h81, 32'h11223344, 8'h11, 8'h03);
    // ETX byte of the bad frame arrived in IDLE: ignored; the PAD error pulse is long gone
    send_byte(8'h02); send_byte(8'h01); send_byte(8'h01); send_byte(8'h02);
    send_byte(8'h03); send_byte(8'h04); send_byte(8'h11);
    check_eq("t4_pad_err", 64'(frame_err), 64'd1);
    @(negedge clk);
    check_eq("t4_pad_err_width", 64'(frame_err), 64'd0);
    check_eq("t4_pad_idle", 64'(busy), 64'd0);
    send_frame(8'h05, 32'hCAFEF00D, 8'h00, 8'h04);
    check_eq("t4_etx_err", 64'(frame_err), 64'd1);
    check_eq("t4_etx_no_valid", 64'(bus.cmd_valid), 64'd0);
    @(negedge clk);
    check_eq("t4_err_count", 64'(ferr_cnt - ferr0), 64'd3);
    check_eq("t4_no_accept", 64'(acc_cnt - acc0), 64'd0);
    send_frame(8'h23, 32'h89ABCDEF, 8'h00, 8'h03);
    check_eq("t4_good_valid", 64'(bus.cmd_valid), 64'd1);
    check_eq("t4_good_cmd", 64'({bus.cmd_write, bus.cmd_addr, bus.cmd_wdata}), {25'd0, 1'b0, 7'h23, 32'h89ABCDEF});
    @(negedge clk);

    // Inter-byte timeout of 16 cycles
    bus.cmd_ready = 1'b1;
    acc0 = acc_cnt;
    early_err = 0;
    send_byte(8'h02); send_byte(8'hFF); send_byte(8'h04);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i < 16 && frame_err) early_err++;
    end
    check_eq("t5_no_early_err", 64'(early_err), 64'd0);
    check_eq("t5_timeout_err", 64'(frame_err), 64'd1);
    check_eq("t5_busy_drop", 64'(busy), 64'd0);
    @(negedge clk);
    check_eq("t5_err_width", 64'(frame_err), 64'd0);
    check_eq("t5_no_accept", 64'(acc_cnt - acc0), 64'd0);

    // Overrun in ISSUE, then reset mid-frame
    bus.cmd_ready = 1'b0;
    send_frame(8'h81, 32'hDEADBEEF, 8'h00, 8'h03);
    check_eq("t6_overrun_before", 64'(overrun), 64'd0);
    send_byte(8'h02);
    check_eq("t6_overrun_set", 64'(overrun), 64'd1);
    repeat (3) @(negedge clk);
    check_eq("t6_overrun_sticky", 64'(overrun), 64'd1);
    check_eq("t6_pending", 64'({bus.cmd_valid, bus.cmd_write, bus.cmd_addr, bus.cmd_wdata}),
             {24'd0, 1'b1, 1'b1, 7'h01, 32'hDEADBEEF});
    bus.cmd_ready = 1'b1;
    @(negedge clk);
    bus.cmd_ready = 1'b0;
    check_eq("t6_overrun_after_acc", 64'(overrun), 64'd1);
    acc0 = acc_cnt;
    send_byte(8'h02); send_byte(8'h92); send_byte(8'h11);
    rst = 1'b0;
    @(negedge clk);
    check_eq("t6_rst_outputs", 64'({bus.cmd_valid, bus.cmd_write, bus.cmd_addr, bus.cmd_wdata, frame_err, overrun, busy}), 64'd0);
    rst = 1'b1;
    bus.cmd_ready = 1'b1;
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    check_eq("t6_idle_after_rst", 64'(busy), 64'd0);
    send_frame(8'h9A, 32'h01020304, 8'h00, 8'h03);
    check_eq("t6_post_rst_cmd", 64'({bus.cmd_valid, bus.cmd_write, bus.cmd_addr, bus.cmd_wdata}),
             {24'd0, 1'b1, 1'b1, 7'h1A, 32'h01020304});
    @(negedge clk);
    check_eq("t6_accepts", 64'(acc_cnt - acc0), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
